// File: rtl/store_rmw_unit_pkg.sv
// rtl/store_rmw_unit_pkg.sv - shared store-mode and RMW state encodings
package store_rmw_unit_pkg;

    // Same encoding the load-extract path uses for access size.
    typedef enum logic [1:0] {
        MODE_WORD  = 2'd0,
        MODE_BYTE  = 2'd1,
        MODE_HALF  = 2'd2,
        MODE_UNDEF = 2'd3
    } store_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_MERGE = 3'd2,
        ST_WRITE = 3'd3,
        ST_ERR   = 3'd4
    } rmw_state_e;

    // A request is rejected for the undefined mode or a misaligned halfword/word.
    function automatic logic store_req_invalid(input store_mode_e mode, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        if (mode == MODE_UNDEF) bad = 1'b1;
        if (mode == MODE_HALF && addr_lo[0]) bad = 1'b1;
        if (mode == MODE_WORD && addr_lo != 2'b00) bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// rtl/store_lane_merge.sv - replaces the addressed byte/halfword lane of a memory word
module store_lane_merge
    import store_rmw_unit_pkg::*;
#(
    parameter int DATA_BITS = 32
) (
    input  logic [DATA_BITS-1:0] old_word,
    input  logic [DATA_BITS-1:0] new_data,
    input  logic [1:0]           addr_lo,
    input  store_mode_e          mode,
    output logic [DATA_BITS-1:0] merged
);

    // Start from the old word so untouched lanes are preserved, then overlay the new lane.
    always_comb begin
        merged = old_word;
        case (mode)
            MODE_WORD: merged = new_data;
            MODE_BYTE: merged[{addr_lo, 3'b000} +: 8] = new_data[7:0];
            MODE_HALF: begin
                if (addr_lo[1]) merged[31:16] = new_data[15:0];
                else            merged[15:0]  = new_data[15:0];
            end
            default:   merged = old_word;
        endcase
    end

endmodule

// File: rtl/store_rmw_unit.sv
// rtl/store_rmw_unit.sv - word/halfword/byte store unit with read-modify-write sequencing
module store_rmw_unit
    import store_rmw_unit_pkg::*;
#(
    parameter int DATA_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [31:0]          addr,
    input  logic [DATA_BITS-1:0] data,
    input  logic [1:0]           StoreMode,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [31:0]          mem_addr,
    output logic                 mem_rd_en,
    input  logic [DATA_BITS-1:0] mem_rdata,
    output logic                 mem_wr_en,
    output logic [DATA_BITS-1:0] mem_wdata
);

    rmw_state_e           state;
    rmw_state_e           state_nxt;
    logic [31:0]          lat_addr;
    logic [DATA_BITS-1:0] lat_data;
    store_mode_e          lat_mode;
    logic [DATA_BITS-1:0] old_word;
    logic [DATA_BITS-1:0] merged;
    store_mode_e          req_mode;

    assign req_mode = store_mode_e'(StoreMode);
    assign mem_addr = {lat_addr[31:2], 2'b00};

    // Word stores also go through the merger; it simply passes the data through.
    store_lane_merge #(
        .DATA_BITS (DATA_BITS)
    ) u_merge (
        .old_word (old_word),
        .new_data (lat_data),
        .addr_lo  (lat_addr[1:0]),
        .mode     (lat_mode),
        .merged   (merged)
    );

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Request latch on acceptance and capture of the read word one cycle after the read strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_addr <= '0;
            lat_data <= '0;
            lat_mode <= MODE_WORD;
            old_word <= '0;
        end else begin
            if (state == ST_IDLE && start) begin
                lat_addr <= addr;
                lat_data <= data;
                lat_mode <= req_mode;
            end
            if (state == ST_MERGE) old_word <= mem_rdata;
        end
    end

    // Next-state: start is only looked at in IDLE, so requests while busy are dropped.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (store_req_invalid(req_mode, addr[1:0])) state_nxt = ST_ERR;
                    else if (req_mode == MODE_WORD)             state_nxt = ST_WRITE;
                    else                                        state_nxt = ST_READ;
                end
            end
            ST_READ:  state_nxt = ST_MERGE;
            ST_MERGE: state_nxt = ST_WRITE;
            ST_WRITE: state_nxt = ST_IDLE;
            ST_ERR:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decode straight from state; write data is forced to zero outside WRITE.
    always_comb begin
        busy      = (state != ST_IDLE);
        done      = 1'b0;
        err       = 1'b0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        mem_wdata = '0;
        case (state)
            ST_READ:  mem_rd_en = 1'b1;
            ST_WRITE: begin
                mem_wr_en = 1'b1;
                done      = 1'b1;
                mem_wdata = merged;
            end
            ST_ERR: begin
                done = 1'b1;
                err  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
